// File: rtl/acc_dcache_arbiter.sv
// acc_dcache_arbiter: shares one data-cache request port between NrPorts
// requesters (port 0 = CVA6 LSU, port 1 = vector unit). Round-robin grant,
// grant held until handshake, in-order tag FIFO routes responses back,
// outstanding limit and a flush/drain handshake for fences.
// Optional performance counters are enabled with `define ACC_DCACHE_ARB_PERF_EN.
module acc_dcache_arbiter #(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 7
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrPorts-1:0]                req_valid_i,
    output logic [NrPorts-1:0]                req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]      req_addr_i,
    input  logic [NrPorts-1:0]                req_we_i,
    input  logic [NrPorts*DataWidth/8-1:0]    req_be_i,
    input  logic [NrPorts*DataWidth-1:0]      req_wdata_i,
    output logic [NrPorts-1:0]                rsp_valid_o,
    output logic [DataWidth-1:0]              rsp_rdata_o,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic [AddrWidth-1:0]              mem_addr_o,
    output logic                              mem_we_o,
    output logic [DataWidth/8-1:0]            mem_be_o,
    output logic [DataWidth-1:0]              mem_wdata_o,
    input  logic                              mem_rsp_valid_i,
    input  logic [DataWidth-1:0]              mem_rsp_rdata_i,
    input  logic                              flush_i,
    output logic                              flush_ack_o,
    output logic                              unexpected_rsp_o,
    output logic [3:0]                        outstanding_o,
    output logic [NrPorts*32-1:0]             perf_grant_cnt_o,
    output logic [31:0]                       perf_stall_cnt_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned TagW    = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic [1:0] {ARB, LOCKED, DRAIN} state_e;

    state_e          state_q;
    logic [TagW-1:0] rr_ptr_q;
    logic [TagW-1:0] lock_g_q;
    logic            flush_pend_q;
    logic            init_q;
    logic [3:0]      count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [TagW-1:0] tag_mem_q [MaxOutstanding];

    logic            active;
    logic            any_valid;
    logic            found;
    logic [TagW-1:0] grant_g;
    logic [TagW-1:0] sel_g;
    logic [TagW-1:0] rr_next;
    logic [TagW-1:0] head_tag;
    logic            mem_valid;
    logic            hs;
    logic            push;
    logic            pop;

    logic [AddrWidth-1:0] addr_arr  [NrPorts];
    logic [BeWidth-1:0]   be_arr    [NrPorts];
    logic [DataWidth-1:0] wdata_arr [NrPorts];

    // Outputs stay quiet while reset is held and for the first cycle after it.
    assign active    = rst_ni & init_q;
    assign any_valid = |req_valid_i;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_g = rr_ptr_q;
        found   = 1'b0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            if (!found && req_valid_i[(int'(rr_ptr_q) + i) % int'(NrPorts)]) begin
                grant_g = TagW'((int'(rr_ptr_q) + i) % int'(NrPorts));
                found   = 1'b1;
            end
        end
    end

    // Request valid: ARB offers only below the limit (registered count, so a pop
    // never frees a slot in the same cycle); a flush pulse in ARB blocks the grant.
    always_comb begin
        mem_valid = 1'b0;
        case (state_q)
            ARB:     mem_valid = active && any_valid && !flush_i &&
                                 (count_q < 4'(MaxOutstanding));
            LOCKED:  mem_valid = active;
            default: mem_valid = 1'b0;
        endcase
    end

    assign sel_g    = (state_q == LOCKED) ? lock_g_q : grant_g;
    assign hs       = mem_valid & mem_req_ready_i;
    assign push     = hs;
    assign pop      = active & mem_rsp_valid_i & (count_q != 4'd0);
    assign head_tag = tag_mem_q[rd_ptr_q];
    assign rr_next  = (sel_g == TagW'(NrPorts - 1)) ? '0 : sel_g + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < int'(NrPorts); gi++) begin : g_port
            assign addr_arr[gi]    = req_addr_i[gi*AddrWidth +: AddrWidth];
            assign be_arr[gi]      = req_be_i[gi*BeWidth +: BeWidth];
            assign wdata_arr[gi]   = req_wdata_i[gi*DataWidth +: DataWidth];
            assign req_ready_o[gi] = hs && (sel_g == TagW'(gi));
            assign rsp_valid_o[gi] = pop && (head_tag == TagW'(gi));
        end
    endgenerate

    assign mem_req_valid_o  = mem_valid;
    assign mem_addr_o       = mem_valid ? addr_arr[sel_g]  : '0;
    assign mem_we_o         = mem_valid & req_we_i[sel_g];
    assign mem_be_o         = mem_valid ? be_arr[sel_g]    : '0;
    assign mem_wdata_o      = mem_valid ? wdata_arr[sel_g] : '0;
    assign rsp_rdata_o      = pop ? mem_rsp_rdata_i : '0;
    assign unexpected_rsp_o = active & mem_rsp_valid_i & (count_q == 4'd0);
    assign flush_ack_o      = active && (state_q == DRAIN) && (count_q == 4'd0);
    assign outstanding_o    = active ? count_q : 4'd0;

    // Arbitration FSM: grant lock while the downstream stalls, flush drain.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            lock_g_q     <= '0;
            flush_pend_q <= 1'b0;
            init_q       <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (hs) begin
                rr_ptr_q <= rr_next;
            end
            case (state_q)
                ARB: begin
                    if (active && flush_i) begin
                        state_q <= DRAIN;
                    end else if (mem_valid && !mem_req_ready_i) begin
                        lock_g_q <= grant_g;
                        state_q  <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (hs) begin
                        state_q      <= (flush_pend_q || flush_i) ? DRAIN : ARB;
                        flush_pend_q <= 1'b0;
                    end else if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count_q == 4'd0) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Tag FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage: which requester issued each in-flight request.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= sel_g;
        end
    end

`ifdef ACC_DCACHE_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NrPorts];
    logic [31:0] stall_cnt_q;

    generate
        for (gi = 0; gi < int'(NrPorts); gi++) begin : g_perf
            // Per-port handshake counter.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    grant_cnt_q[gi] <= 32'd0;
                end else if (hs && (sel_g == TagW'(gi))) begin
                    grant_cnt_q[gi] <= grant_cnt_q[gi] + 32'd1;
                end
            end
            assign perf_grant_cnt_o[gi*32 +: 32] = active ? grant_cnt_q[gi] : 32'd0;
        end
    endgenerate

    // Cycles where someone wants the port but nothing is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else if (active && any_valid && !hs) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign perf_stall_cnt_o = active ? stall_cnt_q : 32'd0;
`else
    assign perf_grant_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_acc_dcache_arbiter.sv
// Directed bench for acc_dcache_arbiter (NrPorts=2, 64-bit, MaxOutstanding=7).
module tb_acc_dcache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_addr;
    logic [1:0]   req_we;
    logic [15:0]  req_be;
    logic [127:0] req_wdata;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_addr;
    logic         mem_we;
    logic [7:0]   mem_be;
    logic [63:0]  mem_wdata;
    logic         mem_rsp_valid;
    logic [63:0]  mem_rsp_rdata;
    logic         flush;
    logic         flush_ack;
    logic         unexpected_rsp;
    logic [3:0]   outstanding;
    logic [63:0]  perf_grant_cnt;
    logic [31:0]  perf_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] ADDR0  = 64'h0000_1000;
    localparam logic [63:0] ADDR1  = 64'h0000_2000;
    localparam logic [63:0] WDATA0 = 64'hAAAA_0000;
    localparam logic [63:0] WDATA1 = 64'hBBBB_1111;

    always #5 clk = ~clk;

    acc_dcache_arbiter dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_we_i         (req_we),
        .req_be_i         (req_be),
        .req_wdata_i      (req_wdata),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_we_o         (mem_we),
        .mem_be_o         (mem_be),
        .mem_wdata_o      (mem_wdata),
        .mem_rsp_valid_i  (mem_rsp_valid),
        .mem_rsp_rdata_i  (mem_rsp_rdata),
        .flush_i          (flush),
        .flush_ack_o      (flush_ack),
        .unexpected_rsp_o (unexpected_rsp),
        .outstanding_o    (outstanding),
        .perf_grant_cnt_o (perf_grant_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic [1:0] v, input logic rdy, input logic rv,
                         input logic [63:0] rd, input logic fl);
        req_valid     = v;
        mem_req_ready = rdy;
        mem_rsp_valid = rv;
        mem_rsp_rdata = rd;
        flush         = fl;
        #1;
    endtask

    initial begin
        req_addr  = {ADDR1, ADDR0};
        req_wdata = {WDATA1, WDATA0};
        req_we    = 2'b10;
        req_be    = 16'hF00F;
        rst_n     = 1'b0;
        #1;
        drive(2'b11, 1'b1, 1'b1, 64'h55, 1'b0);

        // Reset held with activity on the inputs: everything quiet.
        cyc(); cyc();
        check("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("rst_unexpected", {63'd0, unexpected_rsp}, 64'd0);
        check("rst_outstanding", {60'd0, outstanding}, 64'd0);
        cyc();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        check("post_rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("post_rst_addr", mem_addr, 64'd0);

        // A: both ports valid, responses two cycles after each grant.
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_rdy;
            logic [1:0] exp_rsp;
            logic [3:0] exp_out;
            cyc();
            drive((i < 4) ? 2'b11 : 2'b00, 1'b1, (i >= 2), 64'hD000 + 64'(i), 1'b0);
            exp_rdy = (i < 4) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = (i >= 2) ? (((i - 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            case (i)
                0: exp_out = 4'd0;
                1: exp_out = 4'd1;
                5: exp_out = 4'd1;
                default: exp_out = 4'd2;
            endcase
            check($sformatf("A%0d_req_ready", i), {62'd0, req_ready}, {62'd0, exp_rdy});
            check($sformatf("A%0d_rsp_valid", i), {62'd0, rsp_valid}, {62'd0, exp_rsp});
            check($sformatf("A%0d_outstanding", i), {60'd0, outstanding}, {60'd0, exp_out});
            check($sformatf("A%0d_rdata", i), rsp_rdata, (i >= 2) ? 64'hD000 + 64'(i) : 64'd0);
            if (i < 4) begin
                check($sformatf("A%0d_addr", i), mem_addr, (i % 2 == 0) ? ADDR0 : ADDR1);
                check($sformatf("A%0d_we", i), {63'd0, mem_we}, (i % 2 == 0) ? 64'd0 : 64'd1);
            end
        end
        check("A_be_idle", {56'd0, mem_be}, 64'd0);

        // B: port 1 stalled downstream; grant locked while port 0 joins.
        cyc(); drive(2'b10, 1'b0, 1'b0, 64'd0, 1'b0);
        check("B0_valid", {63'd0, mem_req_valid}, 64'd1);
        check("B0_addr", mem_addr, ADDR1);
        check("B0_be", {56'd0, mem_be}, 64'hF0);
        check("B0_ready", {62'd0, req_ready}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(); drive(2'b11, (i == 3), 1'b0, 64'd0, 1'b0);
            check($sformatf("B%0d_addr", i), mem_addr, ADDR1);
            check($sformatf("B%0d_wdata", i), mem_wdata, WDATA1);
            check($sformatf("B%0d_ready", i), {62'd0, req_ready}, (i == 3) ? 64'd2 : 64'd0);
        end
        cyc(); drive(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        check("B4_ready", {62'd0, req_ready}, 64'd1);
        check("B4_addr", mem_addr, ADDR0);
        cyc(); drive(2'b00, 1'b1, 1'b1, 64'h11, 1'b0);
        check("B5_rsp", {62'd0, rsp_valid}, 64'd2);
        cyc(); drive(2'b00, 1'b1, 1'b1, 64'h22, 1'b0);
        check("B6_rsp", {62'd0, rsp_valid}, 64'd1);

        // C: fill to the limit, then one pop frees a slot only a cycle later.
        for (int i = 0; i < 7; i++) begin
            cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
            check($sformatf("C%0d_ready", i), {62'd0, req_ready}, 64'd1);
        end
        cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        check("C_full_outstanding", {60'd0, outstanding}, 64'd7);
        check("C_full_valid", {63'd0, mem_req_valid}, 64'd0);
        cyc(); drive(2'b01, 1'b1, 1'b1, 64'h33, 1'b0);
        check("C_pop_rsp", {62'd0, rsp_valid}, 64'd1);
        check("C_pop_no_grant", {63'd0, mem_req_valid}, 64'd0);
        cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        check("C_regrant_valid", {63'd0, mem_req_valid}, 64'd1);
        check("C_regrant_ready", {62'd0, req_ready}, 64'd1);
        check("C_regrant_outstanding", {60'd0, outstanding}, 64'd6);
        for (int i = 0; i < 7; i++) begin
            cyc(); drive(2'b00, 1'b1, 1'b1, 64'h40 + 64'(i), 1'b0);
            check($sformatf("C_drain%0d_rsp", i), {62'd0, rsp_valid}, 64'd1);
        end

        // D: push and pop together at count 3, then 20 pairs to wrap pointers.
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(2'b10, 1'b1, 1'b0, 64'd0, 1'b0);
            check($sformatf("D_fill%0d_ready", i), {62'd0, req_ready}, 64'd2);
        end
        cyc(); drive(2'b10, 1'b1, 1'b1, 64'h77, 1'b0);
        check("D_pp_ready", {62'd0, req_ready}, 64'd2);
        check("D_pp_rsp", {62'd0, rsp_valid}, 64'd2);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("D_pp_outstanding", {60'd0, outstanding}, 64'd3);
        for (int i = 0; i < 20; i++) begin
            logic [1:0] exp_rsp;
            cyc(); drive(2'b11, 1'b1, 1'b1, 64'h100 + 64'(i), 1'b0);
            exp_rsp = (i < 3) ? 2'b10 : (((i - 3) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("D%0d_ready", i), {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
            check($sformatf("D%0d_rsp", i), {62'd0, rsp_valid}, {62'd0, exp_rsp});
            check($sformatf("D%0d_outstanding", i), {60'd0, outstanding}, 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(2'b00, 1'b1, 1'b1, 64'h200, 1'b0);
            check($sformatf("D_tail%0d_rsp", i), {62'd0, rsp_valid}, (i == 1) ? 64'd1 : 64'd2);
        end

        // E: flush with three outstanding; ack one cycle after the last response.
        for (int i = 0; i < 3; i++) begin
            cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        end
        cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b1);
        check("E0_outstanding", {60'd0, outstanding}, 64'd3);
        check("E0_no_grant", {63'd0, mem_req_valid}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(); drive(2'b01, 1'b1, 1'b1, 64'h300, 1'b0);
            check($sformatf("E%0d_no_grant", i), {63'd0, mem_req_valid}, 64'd0);
            check($sformatf("E%0d_ack", i), {63'd0, flush_ack}, 64'd0);
            check($sformatf("E%0d_rsp", i), {62'd0, rsp_valid}, 64'd1);
        end
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("E4_ack", {63'd0, flush_ack}, 64'd1);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("E5_ack", {63'd0, flush_ack}, 64'd0);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b1);
        check("G0_ack", {63'd0, flush_ack}, 64'd0);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("G1_ack", {63'd0, flush_ack}, 64'd1);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("G2_ack", {63'd0, flush_ack}, 64'd0);

        // U: response with nothing outstanding is dropped.
        cyc(); drive(2'b00, 1'b1, 1'b1, 64'h99, 1'b0);
        check("U0_unexpected", {63'd0, unexpected_rsp}, 64'd1);
        check("U0_rsp", {62'd0, rsp_valid}, 64'd0);
        check("U0_rdata", rsp_rdata, 64'd0);
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
        check("U1_unexpected", {63'd0, unexpected_rsp}, 64'd0);
        check("U1_outstanding", {60'd0, outstanding}, 64'd0);

        // R: reset while LOCKED with one tag pending.
        cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        cyc(); drive(2'b01, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc(); drive(2'b01, 1'b0, 1'b0, 64'd0, 1'b0);
        check("R_locked_valid", {63'd0, mem_req_valid}, 64'd1);
        check("R_locked_outstanding", {60'd0, outstanding}, 64'd1);
        cyc(); rst_n = 1'b0; drive(2'b01, 1'b0, 1'b0, 64'd0, 1'b0);
        check("R_in_rst_valid", {63'd0, mem_req_valid}, 64'd0);
        check("R_in_rst_outstanding", {60'd0, outstanding}, 64'd0);
        cyc(); rst_n = 1'b1; drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        check("R_after_valid", {63'd0, mem_req_valid}, 64'd0);
        check("R_after_ready", {62'd0, req_ready}, 64'd0);
        cyc(); drive(2'b00, 1'b1, 1'b1, 64'h5A, 1'b0);
        check("R_stale_unexpected", {63'd0, unexpected_rsp}, 64'd1);
        check("R_stale_rsp", {62'd0, rsp_valid}, 64'd0);

        // P: five port-0 grants, then read the counters.
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
            check($sformatf("P%0d_ready", i), {62'd0, req_ready}, 64'd1);
        end
        cyc(); drive(2'b00, 1'b1, 1'b0, 64'd0, 1'b0);
`ifdef ACC_DCACHE_ARB_PERF_EN
        check("P_grant0", {32'd0, perf_grant_cnt[31:0]}, 64'd5);
`else
        check("P_grant0", {32'd0, perf_grant_cnt[31:0]}, 64'd0);
`endif
        check("P_grant1", {32'd0, perf_grant_cnt[63:32]}, 64'd0);
        check("P_stall", {32'd0, perf_stall_cnt}, 64'd0);
        check("P_outstanding", {60'd0, outstanding}, 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
